alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_decode.sv | 78 +++++++
 rtl/alu_issue_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op encodings and RV32 decode constants for the ALU issue controller.
package alu_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNCT7_W   = 7;
    localparam int unsigned IMM_W      = 12;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110
    } alu_op_e;

    localparam logic [OPCODE_W-1:0] OPC_R = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_I = 7'b0010011;

    localparam logic [FUNCT7_W-1:0] F7_ZERO = 7'b0000000;
    localparam logic [FUNCT7_W-1:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32 R/I-type decoder: instruction word -> ALU op, immediate select, illegal flag.
module alu_decode
    import alu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output alu_op_e            alu_ctrl,
    output logic               use_imm,
    output logic               illegal
);

    logic [OPCODE_W-1:0] opcode;
    logic [2:0]          funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic                is_r;
    logic                is_i;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign is_r   = (opcode == OPC_R);
    assign is_i   = (opcode == OPC_I);

    // Map funct3/funct7 onto the supported op subset; anything unmatched stays illegal.
    always_comb begin
        alu_ctrl = ALU_ADD;
        use_imm  = is_i;
        illegal  = 1'b1;
        if (is_r || is_i) begin
            case (funct3)
                3'b000: begin
                    // I-type funct7 bits are immediate, so ADDI is always an add
                    if (is_i || funct7 == F7_ZERO) begin
                        alu_ctrl = ALU_ADD;
                        illegal  = 1'b0;
                    end else if (funct7 == F7_ALT) begin
                        alu_ctrl = ALU_SUB;
                        illegal  = 1'b0;
                    end
                end
                3'b111: begin
                    if (is_i || funct7 == F7_ZERO) begin
                        alu_ctrl = ALU_AND;
                        illegal  = 1'b0;
                    end
                end
                3'b110: begin
                    if (is_i || funct7 == F7_ZERO) begin
                        alu_ctrl = ALU_OR;
                        illegal  = 1'b0;
                    end
                end
                3'b100: begin
                    if (is_i || funct7 == F7_ZERO) begin
                        alu_ctrl = ALU_XOR;
                        illegal  = 1'b0;
                    end
                end
                3'b001: begin
                    if (funct7 == F7_ZERO) begin
                        alu_ctrl = ALU_SLL;
                        illegal  = 1'b0;
                    end
                end
                3'b101: begin
                    // funct7 0100000 is SRA/SRAI, which is not supported
                    if (funct7 == F7_ZERO) begin
                        alu_ctrl = ALU_SRL;
                        illegal  = 1'b0;
                    end
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes one RV32 ALU instruction, drives a registered ALU, returns the result.
// Optional statistics counters are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INSTR_W-1:0]    req_instr,
    input  logic [WIDTH-1:0]      req_rs1,
    input  logic [WIDTH-1:0]      req_rs2,
    output logic [WIDTH-1:0]      alu_operand_a,
    output logic [WIDTH-1:0]      alu_operand_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic                  alu_zero,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]           stat_issued,
    output logic [15:0]           stat_illegal
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e           state_q;
    state_e           state_d;
    alu_op_e          dec_ctrl;
    logic             dec_use_imm;
    logic             dec_illegal;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] operand_b_sel;
    logic             accept_legal;
    logic             accept_illegal;
    logic             capture;

    alu_decode u_decode (
        .instr    (req_instr),
        .alu_ctrl (dec_ctrl),
        .use_imm  (dec_use_imm),
        .illegal  (dec_illegal)
    );

    assign imm_sext      = {{(WIDTH-IMM_W){req_instr[31]}}, req_instr[31:20]};
    assign operand_b_sel = dec_use_imm ? imm_sext : req_rs2;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath load strobes.
    always_comb begin
        state_d        = state_q;
        accept_legal   = 1'b0;
        accept_illegal = 1'b0;
        capture        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (dec_illegal) begin
                        accept_illegal = 1'b1;
                        state_d        = ST_RESP;
                    end else begin
                        accept_legal = 1'b1;
                        state_d      = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags registered from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
        end else begin
            req_ready <= (state_d == ST_IDLE);
            rsp_valid <= (state_d == ST_RESP);
        end
    end

    // ALU operands and op are loaded only on a legal accept and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_ctrl      <= '0;
        end else if (accept_legal) begin
            alu_operand_a <= req_rs1;
            alu_operand_b <= operand_b_sel;
            alu_ctrl      <= ALU_CTRL_W'(dec_ctrl);
        end
    end

    // Response payload: forced zero for illegal, ALU capture in WAIT, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (accept_illegal) begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b1;
        end else if (capture) begin
            rsp_result  <= alu_result;
            rsp_zero    <= alu_zero;
            rsp_illegal <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    // Saturating counters of accepted legal and illegal requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
        end else begin
            if (accept_legal && (stat_issued != '1)) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (accept_illegal && (stat_illegal != '1)) begin
                stat_illegal <= stat_illegal + 16'd1;
            end
        end
    end
`endif

endmodule
